// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding and default key length,
// used by the fill, shuffle and decrypt stages.
package rc4_pkg;

  localparam int KEY_LEN_DEF = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ_SI  = 3'd1,
    WAIT_SI  = 3'd2,
    READ_SJ  = 3'd3,
    WAIT_SJ  = 3'd4,
    WRITE_SI = 3'd5,
    WRITE_SJ = 3'd6,
    FINISH   = 3'd7
  } state_t;

endpackage

// File: rtl/shuffle_memory_key_byte_select.sv
// Selects key byte i_idx from the latched key; byte 0 is the most-significant byte.
module key_byte_select #(
  parameter int KEY_LEN = 3,
  parameter int KIW     = 2
) (
  input  logic [8*KEY_LEN-1:0] i_key,
  input  logic [KIW-1:0]       i_idx,
  output logic [7:0]           o_byte
);

  always_comb begin
    o_byte = 8'd0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (i_idx == KIW'(k)) o_byte = i_key[8*(KEY_LEN-1-k) +: 8];
    end
  end

endmodule

// File: rtl/shuffle_memory.sv
// RC4 key-schedule shuffle over an external 256x8 S-memory (1-cycle read).
// Optional busy output enabled by defining SHUFFLE_BUSY_OUT_EN.
module shuffle_memory
  import rc4_pkg::*;
#(
  parameter int KEY_LEN = KEY_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  output logic [7:0]           mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 mem_we,
  input  logic [7:0]           mem_rdata,
  output logic                 finish
`ifdef SHUFFLE_BUSY_OUT_EN
  ,
  output logic                 busy
`endif
);

  localparam int KIW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  state_t               r_state, w_next;
  logic [7:0]           r_i, r_j, r_si, r_sj;
  logic [KIW-1:0]       r_kidx;
  logic [8*KEY_LEN-1:0] r_key;
  logic [7:0]           w_kbyte;

  key_byte_select #(.KEY_LEN(KEY_LEN), .KIW(KIW)) u_ksel (
    .i_key  (r_key),
    .i_idx  (r_kidx),
    .o_byte (w_kbyte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_addr  = 8'd0;
    mem_wdata = 8'd0;
    mem_we    = 1'b0;
    finish    = 1'b0;
    case (r_state)
      IDLE:     if (start) w_next = READ_SI;
      READ_SI:  begin mem_addr = r_i; w_next = WAIT_SI; end
      WAIT_SI:  begin mem_addr = r_i; w_next = READ_SJ; end
      READ_SJ:  begin mem_addr = r_j; w_next = WAIT_SJ; end
      WAIT_SJ:  begin mem_addr = r_j; w_next = WRITE_SI; end
      WRITE_SI: begin
        mem_addr  = r_i;
        mem_wdata = r_sj;
        mem_we    = 1'b1;
        w_next    = WRITE_SJ;
      end
      WRITE_SJ: begin
        mem_addr  = r_j;
        mem_wdata = r_si;
        mem_we    = 1'b1;
        w_next    = (r_i == 8'hFF) ? FINISH : READ_SI;
      end
      FINISH: begin finish = 1'b1; w_next = IDLE; end
      default:  w_next = IDLE;
    endcase
  end

  // Both writes happen even when i==j; sj==si then, so S is left intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i    <= 8'd0;
      r_j    <= 8'd0;
      r_si   <= 8'd0;
      r_sj   <= 8'd0;
      r_kidx <= '0;
      r_key  <= '0;
    end else begin
      case (r_state)
        IDLE:    if (start) r_key <= secret_key;
        WAIT_SI: begin
          r_si <= mem_rdata;
          r_j  <= r_j + mem_rdata + w_kbyte;
        end
        WAIT_SJ: r_sj <= mem_rdata;
        WRITE_SJ: begin
          r_i    <= r_i + 8'd1;
          r_kidx <= (r_kidx == KIW'(KEY_LEN-1)) ? '0 : r_kidx + KIW'(1);
        end
        FINISH: begin
          r_i    <= 8'd0;
          r_j    <= 8'd0;
          r_kidx <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SHUFFLE_BUSY_OUT_EN
  assign busy = (r_state != IDLE) && (r_state != FINISH);
`endif

endmodule

// File: tb/tb_shuffle_memory.sv
// Self-checking bench for shuffle_memory: RAM model plus software KSA reference.
module tb_shuffle_memory;

  localparam int KL = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [8*KL-1:0] secret_key = '0;
  logic [7:0]      mem_addr, mem_wdata, mem_rdata;
  logic            mem_we, finish;
  logic            busy_w;

  logic [7:0] ram   [256];
  logic [7:0] ref_s [256];
  logic       ram_init = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;

  shuffle_memory #(.KEY_LEN(KL)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .secret_key (secret_key),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .finish     (finish)
`ifdef SHUFFLE_BUSY_OUT_EN
    ,
    .busy       (busy_w)
`endif
  );

`ifndef SHUFFLE_BUSY_OUT_EN
  assign busy_w = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'(k);
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  task automatic load_identity();
    @(negedge clk);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
    for (int k = 0; k < 256; k++) ref_s[k] = 8'(k);
  endtask

  // Reference: textbook KSA applied to ref_s in place.
  task automatic model_ksa(input logic [8*KL-1:0] key);
    int j;
    logic [7:0] t;
    j = 0;
    for (int i = 0; i < 256; i++) begin
      j = (j + int'(ref_s[i]) + int'(key[8*(KL-1-(i % KL)) +: 8])) % 256;
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
    end
  endtask

  // Leaves the bench at the negedge right after the accepting edge.
  task automatic go(input logic [8*KL-1:0] key);
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges from the accepting edge until finish (bounded).
  task automatic wait_finish(output int edges);
    edges = 0;
    while (finish !== 1'b1 && edges < 2000) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic check_mem(input string name);
    int bad, first;
    bad = 0; first = -1;
    for (int k = 0; k < 256; k++)
      if (ram[k] !== ref_s[k]) begin bad++; if (first < 0) first = k; end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d bytes differ, first S[%0d] got %h want %h",
               name, bad, first, ram[first], ref_s[first]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({mem_addr, mem_wdata, mem_we, finish, busy_w} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h wdata=%h we=%b fin=%b busy=%b want all 0",
               mem_addr, mem_wdata, mem_we, finish, busy_w);
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({mem_addr, mem_we, finish, busy_w} !== 11'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got addr=%h we=%b fin=%b busy=%b want 0",
               mem_addr, mem_we, finish, busy_w);
    end
  endtask

  task automatic test_key_010203();
    int e;
    load_identity();
    go(24'h010203);
    repeat (6) @(negedge clk);
    n_chk++;
    if (ram[0] !== 8'd1 || ram[1] !== 8'd0) begin
      n_fail++;
      $display("FAIL k010203_i0: got S0=%h S1=%h want 01 00", ram[0], ram[1]);
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if (ram[1] !== 8'd3 || ram[3] !== 8'd0) begin
      n_fail++;
      $display("FAIL k010203_i1: got S1=%h S3=%h want 03 00", ram[1], ram[3]);
    end
    wait_finish(e);
    e += 12;
    n_chk++;
    if (e != 1536) begin
      n_fail++;
      $display("FAIL k010203_latency: got %0d cycles want 1536", e);
    end
    model_ksa(24'h010203);
    check_mem("k010203_final");
  endtask

  task automatic test_key_zero();
    int e, wecnt;
    load_identity();
    go(24'h000000);
    wecnt = 0;
    for (int k = 0; k < 6; k++) begin
      wecnt += int'(mem_we);
      @(negedge clk);
    end
    n_chk++;
    if (wecnt != 2 || ram[0] !== 8'd0 || ram[1] !== 8'd1) begin
      n_fail++;
      $display("FAIL zero_i0: got writes=%0d S0=%h S1=%h want 2 00 01", wecnt, ram[0], ram[1]);
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if (ram[1] !== 8'd1 || ram[2] !== 8'd2) begin
      n_fail++;
      $display("FAIL zero_i1: got S1=%h S2=%h want 01 02", ram[1], ram[2]);
    end
    repeat (6) @(negedge clk);
    n_chk++;
    if (ram[2] !== 8'd3 || ram[3] !== 8'd2) begin
      n_fail++;
      $display("FAIL zero_i2: got S2=%h S3=%h want 03 02", ram[2], ram[3]);
    end
    wait_finish(e);
    model_ksa(24'h000000);
    @(negedge clk);
    check_mem("zero_final");
  endtask

  task automatic test_random_full();
    logic [8*KL-1:0] key;
    int e, busy_cnt;
    key = 24'($urandom);
    load_identity();
    go(key);
    secret_key = ~key;  // must be ignored after acceptance
    e = 0; busy_cnt = 0;
    while (finish !== 1'b1 && e < 2000) begin
      busy_cnt += int'(busy_w);
      @(negedge clk);
      e++;
    end
    n_chk++;
    if (e != 1536) begin
      n_fail++;
      $display("FAIL rand_latency: got %0d cycles want 1536", e);
    end
`ifdef SHUFFLE_BUSY_OUT_EN
    n_chk++;
    if (busy_cnt != 1536 || busy_w !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_window: got %0d busy cycles, busy@finish=%b want 1536 and 0",
               busy_cnt, busy_w);
    end
`endif
    @(negedge clk);
    n_chk++;
    if (finish !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_finish_width: finish still %b one cycle later, want 0", finish);
    end
    model_ksa(key);
    check_mem("rand_final");
  endtask

  task automatic test_start_held();
    logic [8*KL-1:0] key;
    int e, e2, extra;
    key = 24'($urandom);
    load_identity();
    @(negedge clk);
    secret_key = key;
    start = 1'b1;
    @(negedge clk);
    wait_finish(e);
    n_chk++;
    if (e != 1536) begin
      n_fail++;
      $display("FAIL held_first_latency: got %0d cycles want 1536", e);
    end
    // finish -> IDLE -> accept: next finish 1538 edges later
    e2 = 0;
    do begin
      @(negedge clk);
      e2++;
      if (e2 == 3) start = 1'b0;
    end while (finish !== 1'b1 && e2 < 2000);
    n_chk++;
    if (e2 != 1538) begin
      n_fail++;
      $display("FAIL held_second_start: got %0d cycles between finishes want 1538", e2);
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      extra += int'(finish);
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL held_no_third: got %0d extra finish pulses want 0", extra);
    end
    model_ksa(key);
    model_ksa(key);
    check_mem("held_final");
  endtask

  task automatic test_reset_mid();
    logic [8*KL-1:0] key;
    int e, fin_cnt, we_cnt;
    key = 24'($urandom);
    load_identity();
    go(key);
    repeat (700) @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({mem_addr, mem_wdata, mem_we, finish, busy_w} !== 19'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got addr=%h wdata=%h we=%b fin=%b busy=%b want 0",
               mem_addr, mem_wdata, mem_we, finish, busy_w);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 256; k++) ref_s[k] = ram[k];
    fin_cnt = 0; we_cnt = 0;
    repeat (1600) begin
      @(negedge clk);
      fin_cnt += int'(finish);
      we_cnt += int'(mem_we);
    end
    n_chk++;
    if (fin_cnt != 0 || we_cnt != 0) begin
      n_fail++;
      $display("FAIL midreset_quiet: got finish=%0d writes=%0d want 0 0", fin_cnt, we_cnt);
    end
    check_mem("midreset_frozen");
    key = 24'($urandom);
    load_identity();
    go(key);
    wait_finish(e);
    n_chk++;
    if (e != 1536) begin
      n_fail++;
      $display("FAIL midreset_restart_latency: got %0d cycles want 1536", e);
    end
    model_ksa(key);
    @(negedge clk);
    check_mem("midreset_restart_final");
  endtask

  initial begin
    test_reset();
    test_key_010203();
    test_key_zero();
    test_random_full();
    test_start_held();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shuffle_memory.md
SHUFFLE_MEMORY -- requirements
Module: shuffle_memory

Interface
REQ-001 The block SHALL expose parameter KEY_LEN, default 3, giving the number of secret-key bytes.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset. Reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle request to begin the key-schedule shuffle, sampled in IDLE only.
REQ-005 The block SHALL have port secret_key, input, 8*KEY_LEN, the key. Byte 0 is the most-significant byte.
REQ-006 The block SHALL have port mem_addr, output, 8, the S-memory address.
REQ-007 The block SHALL have port mem_wdata, output, 8, the S-memory write data.
REQ-008 The block SHALL have port mem_we, output, 1, the S-memory write enable.
REQ-009 The block SHALL have port mem_rdata, input, 8, the S-memory read data. It is valid in the cycle after the address is presented (1-cycle synchronous read).
REQ-010 The block SHALL have port finish, output, 1, a one-cycle completion pulse.

Function
REQ-011 The block SHALL perform the RC4 key schedule on a memory already holding S[k]=k: for i=0..255, j=(j+S[i]+key[i mod KEY_LEN]) mod 256, then swap S[i] and S[j].
REQ-012 The block SHALL latch secret_key into an internal register on the cycle start is accepted. Later changes to secret_key SHALL be ignored until the next start.
REQ-013 The block SHALL implement the following states:
- IDLE
- READ_SI: mem_addr=i
- WAIT_SI: capture si and update j
- READ_SJ: mem_addr=j
- WAIT_SJ: capture sj
- WRITE_SI: mem_addr=i, mem_wdata=sj, mem_we=1
- WRITE_SJ: mem_addr=j, mem_wdata=si, mem_we=1
- FINISH
REQ-014 State transitions SHALL be:
- IDLE->READ_SI on start
- READ_SI->WAIT_SI->READ_SJ->WAIT_SJ->WRITE_SI->WRITE_SJ, unconditionally
- WRITE_SJ->FINISH if i==255, else WRITE_SJ->READ_SI
- FINISH->IDLE
REQ-015 At the end of WAIT_SI the block SHALL load si<=mem_rdata and j<=j+mem_rdata+keybyte, using 8-bit wrap-around arithmetic.
REQ-016 At the end of WRITE_SJ the block SHALL increment i. The key index SHALL advance modulo KEY_LEN using a counter, with no divider.
REQ-017 mem_we SHALL be 1 only in WRITE_SI and WRITE_SJ. Outside the active states, mem_addr, mem_wdata and mem_we SHALL be 0.
REQ-018 finish SHALL be 1 only in FINISH. It SHALL assert exactly 1536 cycles after the cycle in which start was accepted.
REQ-019 When i==j, the block SHALL still perform both writes. The memory SHALL end up unchanged at that address.
REQ-020 A start asserted outside IDLE SHALL be ignored.
REQ-021 In FINISH the block SHALL clear i, j and the key index to 0.

Reset
REQ-022 While rst=1, the block SHALL force state=IDLE and set i, j, si, sj, the key index and the key register to 0.
REQ-023 Reset mid-shuffle SHALL abort immediately with no further writes. finish SHALL NOT be asserted for the aborted run.
REQ-024 Immediately after reset, all outputs SHALL be 0.

Configuration
REQ-025 Macro SHUFFLE_BUSY_OUT_EN, when defined, SHALL add an output port busy (1 bit). busy SHALL be 1 in every state other than IDLE and FINISH, and 0 under reset.
REQ-026 When SHUFFLE_BUSY_OUT_EN is undefined, the busy port and its logic SHALL be absent. All other behaviour SHALL be identical.

Structure
REQ-027 The state enum and the default key length SHALL live in shared package rc4_pkg, which is reused by the neighbouring fill and decrypt stages.
REQ-028 Key-byte selection (latched key plus modulo-KEY_LEN index giving the 8-bit byte) SHALL be a sub-module named key_byte_select. All other logic SHALL stay in shuffle_memory.

Verification
REQ-029 The bench SHALL model S-memory as a 256x8 RAM with 1-cycle read latency, preloaded with S[k]=k, and SHALL cover the following scenarios:
- Key 0x010203: after iteration i=0, S[0]=1 and S[1]=0. After i=1 (j=3), S[1]=3 and S[3]=0.
- Key 0x000000: iterations i=0 and i=1 are no-ops (j==i). Iteration i=2 swaps S[2]/S[3].
- Full run with a random key: the final memory SHALL equal a software KSA model. finish SHALL pulse once, exactly 1536 cycles after start.
- start held high for the whole run: exactly one shuffle SHALL occur and finish SHALL pulse once. A second shuffle SHALL begin only if start is still high in IDLE afterwards.
- rst asserted at cycle 700: all outputs SHALL be 0 immediately and no finish SHALL occur. A new start SHALL complete normally.
- With SHUFFLE_BUSY_OUT_EN: busy SHALL be 1 for 1536 cycles after start and 0 during finish.
